// File: rtl/timer_array.sv
// Multi-channel memory-mapped up-counter timers with reload, one-shot mode and W1C flags.
// Optional shared prescaler is compiled in when TIMER_PRESCALE_EN is defined.
module timer_array #(
  parameter int          NUM_TIMERS = 4,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h40000100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  irqout,
  output logic [NUM_TIMERS-1:0] irq_vec
);

  logic                         hit;
  logic                         ch_wr;
  logic                         tick;
  logic [NUM_TIMERS-1:0]        flag_vec;
  logic [NUM_TIMERS-1:0][31:0]  th_rd;
  logic [NUM_TIMERS-1:0][31:0]  tl_rd;
  logic [NUM_TIMERS-1:0][31:0]  tcon_rd;

  assign hit   = (addr[31:8] == BASE_ADDR[31:8]) && (addr[1:0] == 2'b00);
  assign ch_wr = wr && hit && !addr[7];

`ifdef TIMER_PRESCALE_EN
  logic        pre_wr;
  logic [15:0] prescale_reg;
  logic [15:0] pcnt_reg;

  assign pre_wr = wr && hit && (addr[7:0] == 8'h84);
  assign tick   = (pcnt_reg == prescale_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_reg <= '0;
      pcnt_reg     <= '0;
    end else if (pre_wr) begin
      prescale_reg <= wdata[15:0];
      pcnt_reg     <= '0;
    end else if (tick) begin
      pcnt_reg     <= '0;
    end else begin
      pcnt_reg     <= pcnt_reg + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
      logic [WIDTH-1:0] th_reg;
      logic [WIDTH-1:0] tl_reg;
      logic             en_reg;
      logic             ie_reg;
      logic             flag_reg;
      logic             oneshot_reg;
      logic             sel;
      logic             wr_th;
      logic             wr_tl;
      logic             wr_tcon;
      logic             overflow;

      assign sel     = ch_wr && (addr[6:4] == 3'(gi));
      assign wr_th   = sel && (addr[3:2] == 2'd0);
      assign wr_tl   = sel && (addr[3:2] == 2'd1);
      assign wr_tcon = sel && (addr[3:2] == 2'd2);
      // A software TL write consumes the tick, so it can never also overflow.
      assign overflow = tick && en_reg && (tl_reg == '1) && !wr_tl;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          th_reg      <= '0;
          tl_reg      <= '0;
          en_reg      <= 1'b0;
          ie_reg      <= 1'b0;
          flag_reg    <= 1'b0;
          oneshot_reg <= 1'b0;
        end else begin
          if (wr_th)
            th_reg <= wdata[WIDTH-1:0];

          if (wr_tl)
            tl_reg <= wdata[WIDTH-1:0];
          else if (overflow)
            tl_reg <= th_reg;
          else if (tick && en_reg)
            tl_reg <= tl_reg + WIDTH'(1);

          if (wr_tcon) begin
            en_reg      <= wdata[0];
            ie_reg      <= wdata[1];
            oneshot_reg <= wdata[3];
          end else if (overflow && oneshot_reg) begin
            en_reg      <= 1'b0;
          end

          // Hardware set beats a simultaneous W1C.
          if (overflow)
            flag_reg <= 1'b1;
          else if (wr_tcon && wdata[2])
            flag_reg <= 1'b0;
        end
      end

      assign th_rd[gi]   = 32'(th_reg);
      assign tl_rd[gi]   = 32'(tl_reg);
      assign tcon_rd[gi] = {28'd0, oneshot_reg, flag_reg, ie_reg, en_reg};
      assign flag_vec[gi] = flag_reg;
      assign irq_vec[gi]  = flag_reg & ie_reg;
    end
  endgenerate

  assign irqout = |irq_vec;

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      if (!addr[7]) begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (addr[6:4] == 3'(i)) begin
            case (addr[3:2])
              2'd0:    rdata = th_rd[i];
              2'd1:    rdata = tl_rd[i];
              2'd2:    rdata = tcon_rd[i];
              default: rdata = '0;
            endcase
          end
        end
      end else if (addr[6:2] == 5'd0) begin
        rdata = 32'(flag_vec);
      end
`ifdef TIMER_PRESCALE_EN
      else if (addr[6:2] == 5'd1) begin
        rdata = 32'(prescale_reg);
      end
`endif
    end
  end

endmodule
